lif_fire_unit: RTL
==================

LIF_FIRE_UNIT -- requirements
Module: lif_fire_unit

Interface
REQ-001 The block SHALL have parameter DEPTH_F, default 21: feature-map side, giving DEPTH_F*DEPTH_F neurons per frame.
REQ-002 The block SHALL have parameter WIDTH_PSUM, default 13: partial-sum width, unsigned.
REQ-003 The block SHALL have parameter WIDTH_RES, default 8: residue (membrane potential) width, unsigned.
REQ-004 The block SHALL have parameter THRESH, default 64: firing threshold, 1..2^WIDTH_RES-1.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port frame_start, input, 1 bit: one-cycle pulse that begins a frame.
REQ-008 The block SHALL have port in_valid, input, 1 bit: the input pair is valid.
REQ-009 The block SHALL have port in_ready, output, 1 bit: the block accepts the input pair.
REQ-010 The block SHALL have port in_psum, input, WIDTH_PSUM bits: this timestep's partial sum for the current neuron.
REQ-011 The block SHALL have port in_res, input, WIDTH_RES bits: the stored residue for the current neuron.
REQ-012 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-013 The block SHALL have port out_ready, input, 1 bit: the downstream output-map memory accepts the result.
REQ-014 The block SHALL have port out_spike, output, 1 bit: the spike for the neuron.
REQ-015 The block SHALL have port out_res, output, WIDTH_RES bits: the updated residue.
REQ-016 The block SHALL have port out_addr, output, 9 bits: neuron index 0..DEPTH_F*DEPTH_F-1, row-major.
REQ-017 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse when the frame completes.
REQ-018 The block SHALL have port spike_cnt, output, 9 bits: total spikes in the frame, stable from frame_done until the next frame_start.

Function
REQ-019 Transfers SHALL occur only on a cycle where valid and ready are both high; valid, once raised, SHALL NOT drop and its payload SHALL NOT change until accepted.
REQ-020 The FSM SHALL have states IDLE, RUN, DRAIN and DONE.
REQ-021 In IDLE, frame_start SHALL clear the neuron counter and spike_cnt and go to RUN; frame_start in any other state SHALL be ignored.
REQ-022 in_ready SHALL be 1 only in RUN, with count < DEPTH_F*DEPTH_F, and with (!out_valid || out_ready).
REQ-023 Arithmetic SHALL be sum = in_psum + in_res at WIDTH_PSUM+1 bits, with no overflow loss.
REQ-024 If sum >= THRESH, the result SHALL be spike=1 and res = min(sum-THRESH, 2^WIDTH_RES-1).
REQ-025 If sum < THRESH, the result SHALL be spike=0 and res = min(sum, 2^WIDTH_RES-1).
REQ-026 Latency SHALL be 1 cycle: an accepted input registers into out_spike/out_res/out_addr and sets out_valid the next cycle.
REQ-027 Back-to-back throughput SHALL be 1 result per cycle while out_ready=1.
REQ-028 out_addr SHALL equal the counter value at acceptance; the counter SHALL increment per accepted input.
REQ-029 spike_cnt SHALL increment when a spike=1 result is accepted downstream, not when it is computed.
REQ-030 After the last (441st by default) input is accepted, RUN SHALL go to DRAIN; DRAIN SHALL go to DONE when out_valid=0 or the last result is accepted.
REQ-031 DONE SHALL assert frame_done for exactly one cycle, then go to IDLE.
REQ-032 Simultaneous output accept and new input accept SHALL replace the output register with no bubble.
REQ-033 out_ready low SHALL hold all outputs stable and deassert in_ready.
REQ-034 in_valid outside RUN SHALL be ignored, with in_ready=0.

Reset
REQ-035 rst_n low SHALL, at any time including mid-frame, asynchronously force IDLE, in_ready=0, out_valid=0, out_spike=0, out_res=0, out_addr=0, frame_done=0, spike_cnt=0 and counter=0.
REQ-036 A partially processed frame SHALL be discarded on reset, and a new frame SHALL require frame_start.

Structure
REQ-037 A shared package snn_pkg SHALL hold DEPTH_F, WIDTH_PSUM, WIDTH_RES, the default THRESH and the FSM state enum typedef.
REQ-038 The single sub-module lif_compute SHALL hold the combinational add/compare/subtract/saturate; the top SHALL hold the FSM, counter, output register and spike counter.

Verification
REQ-039 Bench: psum=50, res=20, THRESH=64 -> spike=1, res=6, addr=0, one cycle after acceptance.
REQ-040 Bench: psum=8191, res=255 -> spike=1, res=255 (saturated); psum=30, res=33 -> spike=0, res=63.
REQ-041 Bench: full frame of 441 pairs with out_ready=1 and in_valid=1 every cycle -> 441 results, addr 0..440 consecutive, frame_done exactly 1 cycle after the final output is accepted, spike_cnt equal to a model count.
REQ-042 Bench: out_ready low for 5 cycles mid-frame -> outputs held constant, in_ready=0, no result lost or duplicated.
REQ-043 Bench: rst_n low after 100 accepts -> all outputs 0 immediately; next frame_start restarts at addr 0.
REQ-044 Bench: frame_start pulsed during RUN -> ignored, counter and spike_cnt unaffected.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared sizing constants and FSM encoding for the LIF spiking-neuron datapath.
package snn_pkg;
  localparam int DEPTH_F    = 21;
  localparam int WIDTH_PSUM = 13;
  localparam int WIDTH_RES  = 8;
  localparam int THRESH     = 64;
  localparam int ADDR_W     = 9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } fsm_state_t;
endpackage

// File: rtl/lif_compute.sv
// Combinational LIF update: integrate psum into residue, fire at THRESH, saturate the residue.
// Zero latency and stateless; the caller owns all flow control.
module lif_compute #(
  parameter int WIDTH_PSUM = 13,
  parameter int WIDTH_RES  = 8,
  parameter int THRESH     = 64
) (
  input  logic [WIDTH_PSUM-1:0] psum_i,
  input  logic [WIDTH_RES-1:0]  res_i,
  output logic                  spike_o,
  output logic [WIDTH_RES-1:0]  res_o
);
  localparam int SW = WIDTH_PSUM + 1;
  localparam logic [SW-1:0] THR     = SW'(THRESH);
  localparam logic [SW-1:0] RES_MAX = SW'((1 << WIDTH_RES) - 1);

  logic [SW-1:0] sum;
  logic [SW-1:0] rem;

  always_comb begin
    sum     = SW'(psum_i) + SW'(res_i);
    spike_o = (sum >= THR);
    rem     = spike_o ? (sum - THR) : sum;
    res_o   = (rem > RES_MAX) ? {WIDTH_RES{1'b1}} : rem[WIDTH_RES-1:0];
  end
endmodule

// File: rtl/lif_fire_unit.sv
// LIF firing stage over a DEPTH_F x DEPTH_F frame: one registered result per accepted psum/residue pair.
// Latency 1 cycle; out_ready low holds the output register and drops in_ready.
module lif_fire_unit #(
  parameter int DEPTH_F    = snn_pkg::DEPTH_F,
  parameter int WIDTH_PSUM = snn_pkg::WIDTH_PSUM,
  parameter int WIDTH_RES  = snn_pkg::WIDTH_RES,
  parameter int THRESH     = snn_pkg::THRESH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH_PSUM-1:0] in_psum,
  input  logic [WIDTH_RES-1:0]  in_res,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_spike,
  output logic [WIDTH_RES-1:0]  out_res,
  output logic [8:0]            out_addr,
  output logic                  frame_done,
  output logic [8:0]            spike_cnt
);
  import snn_pkg::*;

  localparam int         NEURONS  = DEPTH_F * DEPTH_F;
  localparam logic [8:0] N_CNT    = 9'(NEURONS);
  localparam logic [8:0] LAST_IDX = 9'(NEURONS - 1);

  fsm_state_t           state_q, state_d;
  logic [8:0]           cnt_q, cnt_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_spike_q, out_spike_d;
  logic [WIDTH_RES-1:0] out_res_q, out_res_d;
  logic [8:0]           out_addr_q, out_addr_d;
  logic                 frame_done_q, frame_done_d;
  logic [8:0]           spike_cnt_q, spike_cnt_d;

  logic                 spike_c;
  logic [WIDTH_RES-1:0] res_c;
  logic                 acc_in;
  logic                 acc_out;

  lif_compute #(
    .WIDTH_PSUM(WIDTH_PSUM),
    .WIDTH_RES (WIDTH_RES),
    .THRESH    (THRESH)
  ) u_compute (
    .psum_i (in_psum),
    .res_i  (in_res),
    .spike_o(spike_c),
    .res_o  (res_c)
  );

  assign in_ready = (state_q == ST_RUN) && (cnt_q < N_CNT) && (!out_valid_q || out_ready);
  assign acc_in   = in_valid && in_ready;
  assign acc_out  = out_valid_q && out_ready;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    out_valid_d  = out_valid_q;
    out_spike_d  = out_spike_q;
    out_res_d    = out_res_q;
    out_addr_d   = out_addr_q;
    frame_done_d = 1'b0;
    spike_cnt_d  = spike_cnt_q;

    // A new accept overwrites a result leaving in the same cycle, so no bubble.
    if (acc_in) begin
      out_valid_d = 1'b1;
      out_spike_d = spike_c;
      out_res_d   = res_c;
      out_addr_d  = cnt_q;
      cnt_d       = cnt_q + 9'd1;
    end else if (acc_out) begin
      out_valid_d = 1'b0;
    end

    if (acc_out && out_spike_q) begin
      spike_cnt_d = spike_cnt_q + 9'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          state_d     = ST_RUN;
          cnt_d       = '0;
          spike_cnt_d = '0;
        end
      end
      ST_RUN: begin
        if (acc_in && cnt_q == LAST_IDX) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!out_valid_q || acc_out) begin
          state_d      = ST_DONE;
          frame_done_d = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
      out_spike_q  <= 1'b0;
      out_res_q    <= '0;
      out_addr_q   <= '0;
      frame_done_q <= 1'b0;
      spike_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      out_valid_q  <= out_valid_d;
      out_spike_q  <= out_spike_d;
      out_res_q    <= out_res_d;
      out_addr_q   <= out_addr_d;
      frame_done_q <= frame_done_d;
      spike_cnt_q  <= spike_cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_spike  = out_spike_q;
  assign out_res    = out_res_q;
  assign out_addr   = out_addr_q;
  assign frame_done = frame_done_q;
  assign spike_cnt  = spike_cnt_q;
endmodule
